pipelined_mac_unit: RTL and testbench

- Parametrised, pipelined multiply-accumulate unit; successor to the single-cycle 8x8 multiplier used by the NoC processing elements.
- Adds configurable operand width and pipeline depth, signed/unsigned mode, and an optional running accumulator.
- Adds a valid/ready handshake on both sides so routers and PEs can apply backpressure without losing results.

---
 rtl/pipelined_mac_unit.sv | 144 ++++++++++++++
 tb/tb_pipelined_mac_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_mac_unit.sv
// Pipelined signed/unsigned multiply-accumulate with valid/ready on both sides.
// STAGES registers from accept to result; the last one is the output register.
module pipelined_mac_unit #(
    parameter int WIDTH  = 8,
    parameter int ACC_W  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic             signed_mode,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] product
);

    localparam int PW = 2 * WIDTH;
    localparam logic [ACC_W-1:0] HI_MASK = ~ACC_W'({PW{1'b1}});

    generate
        if (ACC_W < PW) begin : g_bad_acc_w
            $error("pipelined_mac_unit: ACC_W must be >= 2*WIDTH");
        end
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("pipelined_mac_unit: STAGES must be 1..4");
        end
    endgenerate

    logic w_advance;
    logic r_out_valid;
    logic [ACC_W-1:0] r_product;
    logic [ACC_W-1:0] r_acc;

    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;
    assign out_valid = r_out_valid;
    assign product   = r_product;

    // One extra operand bit lets a single signed multiplier serve both modes.
    logic signed [WIDTH:0]  w_a;
    logic signed [WIDTH:0]  w_b;
    logic signed [PW-1:0]   w_ax;
    logic signed [PW-1:0]   w_bx;
    logic signed [PW-1:0]   w_mul;
    logic [PW-1:0]          w_p;
    logic [ACC_W-1:0]       w_ext;

    assign w_a   = {signed_mode & num1[WIDTH-1], num1};
    assign w_b   = {signed_mode & num2[WIDTH-1], num2};
    assign w_ax  = PW'(w_a);
    assign w_bx  = PW'(w_b);
    assign w_mul = w_ax * w_bx;
    assign w_p   = w_mul;
    assign w_ext = ACC_W'(w_p)
                 | ((signed_mode && w_p[PW-1]) ? HI_MASK : '0);

    logic [STAGES-1:0]            w_sv;
    logic [STAGES-1:0]            w_se;
    logic [STAGES-1:0]            w_sc;
    logic [STAGES-1:0][ACC_W-1:0] w_sp;

    assign w_sv[0] = in_valid;
    assign w_se[0] = acc_en;
    assign w_sc[0] = acc_clr;
    assign w_sp[0] = w_ext;

    genvar k;
    generate
        for (k = 1; k < STAGES; k++) begin : g_stage
            logic             r_v;
            logic             r_e;
            logic             r_c;
            logic [ACC_W-1:0] r_p;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_v <= 1'b0;
                    r_e <= 1'b0;
                    r_c <= 1'b0;
                    r_p <= '0;
                end else if (w_advance) begin
                    r_v <= w_sv[k-1];
                    r_e <= w_se[k-1];
                    r_c <= w_sc[k-1];
                    r_p <= w_sp[k-1];
                end
            end

            assign w_sv[k] = r_v;
            assign w_se[k] = r_e;
            assign w_sc[k] = r_c;
            assign w_sp[k] = r_p;
        end
    endgenerate

    logic             w_lv;
    logic             w_le;
    logic             w_lc;
    logic [ACC_W-1:0] w_lp;
    logic [ACC_W-1:0] w_sum;
    logic [ACC_W-1:0] w_res;
    logic [ACC_W-1:0] w_acc_nxt;

    assign w_lv = w_sv[STAGES-1];
    assign w_le = w_se[STAGES-1];
    assign w_lc = w_sc[STAGES-1];
    assign w_lp = w_sp[STAGES-1];

    always_comb begin
        w_sum     = r_acc + w_lp;
        w_res     = w_lp;
        w_acc_nxt = r_acc;
        case ({w_le, w_lc})
            2'b01: w_acc_nxt = '0;
            2'b10: begin
                w_res     = w_sum;
                w_acc_nxt = w_sum;
            end
            2'b11: w_acc_nxt = w_lp;
            default: w_acc_nxt = r_acc;
        endcase
    end

    // The accumulator only moves together with a real beat entering the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_product   <= '0;
            r_acc       <= '0;
        end else if (w_advance) begin
            r_out_valid <= w_lv;
            if (w_lv) begin
                r_product <= w_res;
                r_acc     <= w_acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_mac_unit.sv
// Bench for pipelined_mac_unit: two instances (32-bit/2-stage, 16-bit/3-stage)
// checked every cycle against a transaction-level model plus literal cases.
module tb_pipelined_mac_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       iv   [2];
    logic       sm   [2];
    logic       en   [2];
    logic       clr  [2];
    logic       ordy [2];
    logic [7:0] n1   [2];
    logic [7:0] n2   [2];

    logic        irdy0, irdy1, ov0, ov1;
    logic [31:0] p0;
    logic [15:0] p1;
    logic        irdy [2];
    logic        ov   [2];
    logic [31:0] prod [2];

    always_comb begin
        irdy[0] = irdy0;
        irdy[1] = irdy1;
        ov[0]   = ov0;
        ov[1]   = ov1;
        prod[0] = p0;
        prod[1] = {16'h0, p1};
    end

    pipelined_mac_unit #(.WIDTH(8), .ACC_W(32), .STAGES(2)) u0 (
        .clk(clk), .rst(rst),
        .in_valid(iv[0]), .in_ready(irdy0),
        .num1(n1[0]), .num2(n2[0]),
        .signed_mode(sm[0]), .acc_en(en[0]), .acc_clr(clr[0]),
        .out_valid(ov0), .out_ready(ordy[0]), .product(p0)
    );

    pipelined_mac_unit #(.WIDTH(8), .ACC_W(16), .STAGES(3)) u1 (
        .clk(clk), .rst(rst),
        .in_valid(iv[1]), .in_ready(irdy1),
        .num1(n1[1]), .num2(n2[1]),
        .signed_mode(sm[1]), .acc_en(en[1]), .acc_clr(clr[1]),
        .out_valid(ov1), .out_ready(ordy[1]), .product(p1)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] v;
        int          c;
        int          s;
    } ent_t;

    ent_t        q0 [$];
    ent_t        q1 [$];
    logic [31:0] macc [2];
    int          stl  [2];
    logic        hold [2];
    logic [31:0] hp   [2];

    function automatic int stg(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic logic [31:0] msk(input int d);
        return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, want);
        end
    endtask

    // Model: in-order queue of expected results with accept cycle and
    // stall count, so due time = accept + STAGES + stalls in between.
    always @(negedge clk) begin : mon
        ent_t        h;
        ent_t        e;
        int          n;
        logic        eov;
        logic [31:0] pv, res, mk;
        longint      pl;
        for (int d = 0; d < 2; d++) begin
            n = (d == 0) ? q0.size() : q1.size();
            h = '{v: 32'h0, c: 0, s: 0};
            if (n > 0) h = (d == 0) ? q0[0] : q1[0];
            if (rst) begin
                chk("rst_out_valid", {31'h0, ov[d]}, 32'h0);
                chk("rst_product", prod[d], 32'h0);
                chk("rst_in_ready", {31'h0, irdy[d]}, 32'h1);
                if (d == 0) q0.delete();
                else q1.delete();
                macc[d] = 32'h0;
                stl[d]  = 0;
                hold[d] = 1'b0;
            end else begin
                eov = (n > 0) &&
                      ((cyc - h.c - (stl[d] - h.s)) >= stg(d));
                chk("out_valid", {31'h0, ov[d]}, {31'h0, eov});
                chk("in_ready", {31'h0, irdy[d]},
                    {31'h0, (!ov[d] || ordy[d])});
                if (hold[d]) chk("stall_hold", prod[d], hp[d]);
                if (ov[d] && ordy[d] && n > 0) begin
                    chk("product", prod[d], h.v);
                    if (d == 0) void'(q0.pop_front());
                    else void'(q1.pop_front());
                end
                hold[d] = ov[d] && !ordy[d];
                hp[d]   = prod[d];
                if (ov[d] && !ordy[d]) stl[d]++;
                if (iv[d] && irdy[d]) begin
                    mk = msk(d);
                    if (sm[d])
                        pl = longint'($signed(n1[d])) *
                             longint'($signed(n2[d]));
                    else
                        pl = longint'(n1[d]) * longint'(n2[d]);
                    pv = pl[31:0] & mk;
                    if (en[d] && !clr[d]) begin
                        res     = (macc[d] + pv) & mk;
                        macc[d] = res;
                    end else begin
                        res = pv;
                        if (clr[d]) macc[d] = en[d] ? pv : 32'h0;
                    end
                    e.v = res;
                    e.c = cyc;
                    e.s = stl[d];
                    if (d == 0) q0.push_back(e);
                    else q1.push_back(e);
                end
            end
        end
    end

    task automatic send(input int d, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic e, input logic c);
        bit ok = 1'b0;
        iv[d]  = 1'b1;
        n1[d]  = a;
        n2[d]  = b;
        sm[d]  = s;
        en[d]  = e;
        clr[d] = c;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (irdy[d]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("send_accept", {31'h0, ok}, 32'h1);
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
    endtask

    task automatic wait_out(input int d, input logic [31:0] want,
                            input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ov[d] && ordy[d]) begin
                chk(nm, prod[d], want);
                ok = 1'b1;
                break;
            end
        end
        chk({nm, "_seen"}, {31'h0, ok}, 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input int d);
        send(d, 8'd255, 8'd255, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= stg(d) + 1; k++) begin
            @(negedge clk);
            chk("lat_out_valid", {31'h0, ov[d]}, (k == stg(d)) ? 32'h1 : 32'h0);
            if (k == stg(d)) chk("mul_255x255", prod[d], 32'd65025);
        end
        @(posedge clk);
        #1;
        send(d, 8'hFF, 8'h02, 1'b1, 1'b0, 1'b0);
        wait_out(d, (d == 0) ? 32'hFFFF_FFFE : 32'h0000_FFFE, "signed_m1x2");
        send(d, 8'hFF, 8'h02, 1'b0, 1'b0, 1'b0);
        wait_out(d, 32'd510, "unsigned_255x2");
        send(d, 8'd3, 8'd4, 1'b0, 1'b1, 1'b1);
        wait_out(d, 32'd12, "acc_start");
        send(d, 8'd5, 8'd6, 1'b0, 1'b1, 1'b0);
        wait_out(d, 32'd42, "acc_add1");
        send(d, 8'd2, 8'd2, 1'b0, 1'b1, 1'b0);
        wait_out(d, 32'd46, "acc_add2");
        send(d, 8'd7, 8'd7, 1'b0, 1'b1, 1'b1);
        wait_out(d, 32'd49, "acc_restart");
        send(d, 8'd255, 8'd255, 1'b0, 1'b1, 1'b1);
        wait_out(d, 32'd65025, "wrap_first");
        send(d, 8'd255, 8'd255, 1'b0, 1'b1, 1'b0);
        wait_out(d, (d == 0) ? 32'd130050 : 32'd64514, "wrap_second");
    endtask

    task automatic backpressure(input int d);
        logic [31:0] got [4];
        int          k   = 0;
        bit          low = 1'b0;
        fork
            begin
                for (int i = 1; i <= 4; i++)
                    send(d, 8'(i), 8'(i), 1'b0, 1'b0, 1'b0);
            end
            begin
                ordy[d] = 1'b1;
                repeat (2) begin @(posedge clk); #1; end
                ordy[d] = 1'b0;
                repeat (4) begin @(posedge clk); #1; end
                ordy[d] = 1'b1;
            end
            begin
                for (int i = 0; i < 40 && k < 4; i++) begin
                    @(negedge clk);
                    if (ov[d] && !ordy[d] && !irdy[d]) low = 1'b1;
                    if (ov[d] && ordy[d]) begin
                        got[k] = prod[d];
                        k++;
                    end
                end
            end
        join
        chk("bp_count", k, 32'd4);
        for (int i = 0; i < 4 && i < k; i++)
            chk("bp_order", got[i], 32'((i + 1) * (i + 1)));
        chk("bp_in_ready_low", {31'h0, low}, 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_mid(input int d);
        send(d, 8'd5, 8'd5, 1'b0, 1'b1, 1'b1);
        send(d, 8'd6, 8'd6, 1'b0, 1'b1, 1'b0);
        #1;
        rst   = 1'b1;
        iv[d] = 1'b1;
        n1[d] = 8'd9;
        n2[d] = 8'd9;
        #1;
        chk("rst_now_out_valid", {31'h0, ov[d]}, 32'h0);
        chk("rst_now_product", prod[d], 32'h0);
        repeat (2) @(posedge clk);
        #3;
        rst   = 1'b0;
        iv[d] = 1'b0;
        @(posedge clk);
        #1;
        send(d, 8'd2, 8'd3, 1'b0, 1'b1, 1'b0);
        wait_out(d, 32'd6, "post_rst_acc");
    endtask

    task automatic run_rand(input int d);
        bit done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        iv[d] = 1'b0;
                        @(posedge clk);
                        #1;
                    end else begin
                        send(d, 8'($urandom), 8'($urandom), 1'($urandom),
                             $urandom_range(0, 1) == 1,
                             $urandom_range(0, 4) == 0);
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    ordy[d] = $urandom_range(0, 2) != 0;
                end
                ordy[d] = 1'b1;
            end
        join
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected done");
        $fatal(1);
    end

    initial begin
        bit drained = 1'b0;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            iv[d]   = 1'b0;
            sm[d]   = 1'b0;
            en[d]   = 1'b0;
            clr[d]  = 1'b0;
            ordy[d] = 1'b1;
            n1[d]   = 8'h0;
            n2[d]   = 8'h0;
        end
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            directed(d);
            backpressure(d);
            reset_mid(d);
        end
        fork
            run_rand(0);
            run_rand(1);
        join
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        chk("drain", {31'h0, drained}, 32'h1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
